// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : MIPS general-purpose register file feeding the ALU operands.
//            Two combinational read ports (rs -> rd1, rt -> rd2) and one
//            synchronous write port for the writeback result. Register $0
//            is hardwired to zero and has no storage behind it.
// Ports    : clk    - single clock, all state updates on rising edge
//            rst_n  - synchronous active-low reset, clears every register
//            we     - write enable for the write port
//            wa     - write address (ADDR_W bits)
//            wd     - write data (DATA_W bits)
//            ra1    - read address, port 1 (rs)
//            ra2    - read address, port 2 (rt)
//            rd1    - read data, port 1 (ALU operand a)
//            rd2    - read data, port 2 (ALU operand b)
// Config   : REGFILE_BYPASS_EN - when defined, a write in progress is
//            forwarded to a read port addressing the same register in the
//            same cycle (write-first). When undefined, reads return the
//            stored value until the edge (read-first).
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // Current contents of every register as seen by the read muxes.
    logic [DATA_W-1:0] w_regs [c_DEPTH];

    // A write is only meaningful when out of reset and not aimed at $0;
    // the same qualifier gates both the storage update and the bypass.
    logic w_wr_live;
    assign w_wr_live = rst_n && we && (wa != '0);

    genvar gi;
    generate
        for (gi = 0; gi < c_DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // $0 is a constant: it can never hold X and never changes.
                assign w_regs[gi] = '0;
            end else begin : g_live
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (we && (wa == ADDR_W'(gi))) begin
                        r_q <= wd;
                    end
                end
                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    logic w_fwd1;
    logic w_fwd2;

`ifdef REGFILE_BYPASS_EN
    // Each port compares against the write address on its own.
    assign w_fwd1 = w_wr_live && (wa == ra1);
    assign w_fwd2 = w_wr_live && (wa == ra2);
`else
    // Hazards are resolved by the pipeline forwarding unit instead.
    logic w_unused;
    assign w_unused = w_wr_live;
    assign w_fwd1   = 1'b0;
    assign w_fwd2   = 1'b0;
`endif

    always_comb begin
        rd1 = w_regs[ra1];
        rd2 = w_regs[ra2];
        if (w_fwd1) begin
            rd1 = wd;
        end
        if (w_fwd2) begin
            rd2 = wd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Scoreboard bench for reg_file. A driver issues directed and
//            random cycles, computes the expected read data from an
//            array-based model of the register file and queues it; a
//            monitor on the falling edge pops and compares against rd1/rd2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int c_DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] wa = '0;
    logic [DATA_W-1:0] wd = '0;
    logic [ADDR_W-1:0] ra1 = '0;
    logic [ADDR_W-1:0] ra2 = '0;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .ra1  (ra1),
        .ra2  (ra2),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] mdl [c_DEPTH];
    int                n_cmp = 0;
    int                n_bad = 0;

    // Expected read of one port given the current model and the write
    // being presented this cycle.
    function automatic logic [DATA_W-1:0] model_read(
        input logic r, input logic w, input int waddr, input logic [DATA_W-1:0] wdata,
        input int raddr);
        if (raddr == 0) return '0;
        if (c_BYP && r && w && waddr != 0 && waddr == raddr) return wdata;
        return mdl[raddr];
    endfunction

    // One clock cycle of stimulus. Inputs change 1 time unit after the
    // rising edge and stay until the next one; the model is advanced to the
    // state the DUT will hold after that next edge.
    task automatic cycle(input logic r, input logic w, input int waddr,
                         input logic [DATA_W-1:0] wdata, input int a1,
                         input int a2, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        we    = w;
        wa    = ADDR_W'(waddr);
        wd    = wdata;
        ra1   = ADDR_W'(a1);
        ra2   = ADDR_W'(a2);
        if (chk) begin
            e.a1 = ADDR_W'(a1);
            e.a2 = ADDR_W'(a2);
            e.e1 = model_read(r, w, waddr, wdata, a1);
            e.e2 = model_read(r, w, waddr, wdata, a2);
            sb_q.push_back(e);
        end
        if (!r) begin
            for (int k = 0; k < c_DEPTH; k++) mdl[k] = '0;
        end else if (w && waddr != 0) begin
            mdl[waddr] = wdata;
        end
    endtask

    // Monitor: read data is combinational, so it is valid at every falling
    // edge following a queued stimulus.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (rd1 !== e.e1) begin
                n_bad++;
                $display("FAIL rd1 ra1=%0d: got %h expected %h", e.a1, rd1, e.e1);
            end
            n_cmp++;
            if (rd2 !== e.e2) begin
                n_bad++;
                $display("FAIL rd2 ra2=%0d: got %h expected %h", e.a2, rd2, e.e2);
            end
        end
    end

    initial begin
        for (int k = 0; k < c_DEPTH; k++) mdl[k] = '0;

        // Initial reset.
        cycle(1'b0, 1'b0, 0, '0, 0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, '0, 0, 0, 1'b0);

        // Reset clears everything: fill with ones, reset, read all.
        for (int i = 0; i < c_DEPTH; i++) cycle(1'b1, 1'b1, i, 32'hFFFF_FFFF, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, '0, 7, 31, 1'b1);
        cycle(1'b0, 1'b0, 0, '0, 0, 0, 1'b0);
        for (int i = 0; i < c_DEPTH; i++) cycle(1'b1, 1'b0, 0, '0, i, 31 - i, 1'b1);

        // Basic write then read on both ports; neighbour untouched.
        cycle(1'b1, 1'b1, 5, 32'hDEAD_BEEF, 6, 6, 1'b1);
        cycle(1'b1, 1'b0, 0, '0, 5, 5, 1'b1);
        cycle(1'b1, 1'b0, 0, '0, 6, 6, 1'b1);

        // Writes to $0 are dropped, including in the write cycle itself.
        cycle(1'b1, 1'b1, 0, 32'h1234_5678, 0, 0, 1'b1);
        cycle(1'b1, 1'b0, 0, '0, 0, 0, 1'b1);

        // Reset wins over a simultaneous write.
        cycle(1'b0, 1'b1, 9, 32'hA5A5_A5A5, 9, 5, 1'b1);
        cycle(1'b1, 1'b0, 0, '0, 9, 5, 1'b1);
        cycle(1'b1, 1'b1, 9, 32'h0BAD_F00D, 9, 9, 1'b1);
        cycle(1'b1, 1'b0, 0, '0, 9, 9, 1'b1);

        // Read during write on the same address.
        cycle(1'b1, 1'b1, 3, 32'h1, 0, 0, 1'b0);
        cycle(1'b1, 1'b1, 3, 32'h2, 3, 4, 1'b1);
        cycle(1'b1, 1'b0, 0, '0, 3, 3, 1'b1);

        // Sweep pattern, read back through both ports.
        for (int i = 1; i < c_DEPTH; i++) cycle(1'b1, 1'b1, i, DATA_W'(i) * 32'h0101_0101, 0, i, 1'b1);
        for (int i = 0; i < c_DEPTH; i++) cycle(1'b1, 1'b0, 0, '0, i, 31 - i, 1'b1);

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            logic r;
            logic w;
            int   waddr;
            r     = ($urandom_range(0, 39) != 0);
            w     = ($urandom_range(0, 2) != 0);
            waddr = $urandom_range(0, 31);
            cycle(r, w, waddr, $urandom(),
                  ($urandom_range(0, 3) == 0) ? waddr : $urandom_range(0, 31),
                  ($urandom_range(0, 3) == 0) ? waddr : $urandom_range(0, 31), 1'b1);
        end

        // Drain the scoreboard.
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
